acp_arp_counter: RTL and testbench
==================================

// Module: acp_arp_counter
// PURPOSE
//   Upstream azimuth front end for bear_decode. Turns raw radar antenna ACP (azimuth change
//   pulse) and ARP (azimuth reference / north pulse) inputs into a 12-bit angle, and produces
//   the free-running 5 us tick. Both feed the delay-latch stage downstream.
//   Also checks the pulse count per revolution and flags loss of rotation.
// PARAMETERS
//   FILT_LEN     8     clk cycles an input must hold steady before its filtered level changes (2..63)
//   ACP_PER_REV  4096  expected ACP rising edges per revolution (2..4096)
//   TICK_DIV     200   clk cycles per t5us pulse (200 = 5 us at 40 MHz)
//   ACP_TIMEOUT  20000 t5us ticks without an ACP edge before LOST (20000 = 100 ms)
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous reset, active low
//   acp_in     in   1   raw ACP, asynchronous
//   arp_in     in   1   raw ARP, asynchronous
//   angle      out  12  azimuth count, 0 at north; feeds bear_decode.angle
//   angle_vld  out  1   1 = tracking; angle is referenced to ARP
//   arp_pulse  out  1   1-clk pulse on each accepted ARP rising edge
//   t5us       out  1   1-clk pulse every TICK_DIV clk; feeds bear_decode.t5us
//   rev_cnt    out  13  number of ACP edges in the last completed revolution
//   rev_err    out  1   1 = last completed revolution had rev_cnt != ACP_PER_REV
//   lost       out  1   1 = no ACP edge within ACP_TIMEOUT ticks
// BEHAVIOUR
//   - Reset: all state is cleared on a clk edge while reset = 0, including in mid-operation.
//     Outputs angle = 0, angle_vld = 0, arp_pulse = 0, t5us = 0, rev_cnt = 0, rev_err = 0,
//     lost = 0. Filtered levels = 0. State = SEARCH.
//   - Input path, per input: 2-FF synchroniser, then a stability counter. The filtered level
//     takes the synchronised value after FILT_LEN consecutive equal cycles.
//     A rising edge of the filtered level gives a 1-clk edge strobe.
//     Latency, clean input: a 0->1 on acp_in at edge k updates angle at edge k+FILT_LEN+3.
//     A 0->1 on arp_in at edge k raises arp_pulse at edge k+FILT_LEN+3.
//   - Any pulse shorter than FILT_LEN cycles is ignored completely.
//   - t5us: a counter 0..TICK_DIV-1 that runs from reset release and is never stopped.
//     t5us = 1 in the cycle the counter equals TICK_DIV-1.
//   - FSM states SEARCH, TRACK, LOST:
//     SEARCH: ACP edges are ignored for angle; angle_vld = 0. ARP edge -> angle = 0,
//       acp counter = 0, go TRACK. rev_cnt and rev_err are not updated on this first ARP.
//     TRACK: angle_vld = 1.
//       ACP edge -> angle = (angle+1) mod ACP_PER_REV; the acp counter increments and
//       saturates at 8191.
//       ARP edge -> rev_cnt = acp counter; rev_err = (acp counter != ACP_PER_REV);
//       angle = 0; acp counter = 0.
//     ACP and ARP edges in the same cycle: the ACP belongs to the closing revolution, so
//       rev_cnt = acp counter + 1. Angle goes to 0 and the ACP is not applied to the new
//       revolution.
//     ACP timeout: a timer in t5us ticks clears on every ACP edge. When it reaches
//       ACP_TIMEOUT in TRACK or SEARCH -> go LOST, lost = 1, angle_vld = 0, angle held.
//     LOST: the next ACP edge -> lost = 0, go SEARCH. ARP edges in LOST are ignored.
//   - arp_pulse fires on every filtered ARP edge, in every state.
//   - Angle wraps modulo ACP_PER_REV if ARP is missed.
//     rev_cnt still counts the true total, up to the 8191 saturation.
//   - Arithmetic is unsigned throughout. Angle bits above log2(ACP_PER_REV) stay 0.
// TESTING
//   1 Reset, ARP, then 4096 clean ACPs, then ARP -> angle counts 0..4095 and returns to 0
//     on the second ARP; rev_cnt = 4096, rev_err = 0, angle_vld = 1.
//   2 ACP glitch 7 clk wide (FILT_LEN = 8) in TRACK -> angle unchanged.
//     A 9-clk pulse -> angle+1, updated exactly 11 clk after the rising edge.
//   3 Revolution with only 4095 ACPs -> on ARP: rev_cnt = 4095, rev_err = 1, angle = 0.
//     Next revolution has 4096 ACPs -> rev_err = 0.
//   4 ACP and ARP rising edges in the same clk after 4095 ACPs -> rev_cnt = 4096,
//     rev_err = 0, angle = 0, arp_pulse one clk wide.
//   5 ACP stops for 20000 t5us ticks -> lost = 1, angle_vld = 0, angle frozen.
//     ACP resumes -> lost = 0, state SEARCH. Next ARP -> angle_vld = 1, angle = 0.
//   6 Check t5us period is 200 clk with a 1-clk pulse. Assert reset for 1 clk in
//     mid-revolution -> every output at its reset value on the following edge.

Source files
------------

// File: rtl/acp_arp_counter.sv
// Azimuth front end: filters raw ACP/ARP, keeps a north-referenced 12-bit angle,
// checks the per-revolution pulse count, flags loss of rotation and makes the 5 us tick.

module acp_arp_filt #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);
    localparam logic [5:0] FILT_LAST = 6'(FILT_LEN - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [5:0] cnt_q, cnt_d;
    logic       filt_q, filt_d;
    logic       prev_q, prev_d;
    logic       edge_q, edge_d;

    // The counter only runs while the synchronised level disagrees with the
    // filtered one, so any return to the old level restarts the qualification.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cnt_d   = 6'd0;
        filt_d  = filt_q;
        prev_d  = filt_q;
        edge_d  = filt_q & ~prev_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == FILT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= 6'd0;
            filt_q  <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            edge_q  <= edge_d;
        end
    end

    assign rise = edge_q;
endmodule

module acp_arp_counter #(
    parameter int FILT_LEN    = 8,
    parameter int ACP_PER_REV = 4096,
    parameter int TICK_DIV    = 200,
    parameter int ACP_TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        acp_in,
    input  logic        arp_in,
    output logic [11:0] angle,
    output logic        angle_vld,
    output logic        arp_pulse,
    output logic        t5us,
    output logic [12:0] rev_cnt,
    output logic        rev_err,
    output logic        lost
);
    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam int              OW        = $clog2(ACP_TIMEOUT + 1);
    localparam logic [OW-1:0]   TO_VAL    = OW'(ACP_TIMEOUT);
    localparam logic [11:0]     ANG_LAST  = 12'(ACP_PER_REV - 1);
    localparam logic [12:0]     REV_EXP   = 13'(ACP_PER_REV);
    localparam logic [12:0]     CNT_MAX   = 13'h1FFF;

    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOST} state_t;

    logic [1:0] raw, rise;
    logic       acp_e, arp_e;

    assign raw   = {arp_in, acp_in};
    assign acp_e = rise[0];
    assign arp_e = rise[1];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_filt
            acp_arp_filt #(.FILT_LEN(FILT_LEN)) u_filt (
                .clk  (clk),
                .reset(reset),
                .din  (raw[g]),
                .rise (rise[g])
            );
        end
    endgenerate

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [OW-1:0] timer_q, timer_d;
    logic [11:0]   angle_q, angle_d;
    logic [12:0]   acnt_q, acnt_d;
    logic [12:0]   rev_cnt_q, rev_cnt_d;
    logic          rev_err_q, rev_err_d;
    logic          arp_pulse_q, arp_pulse_d;

    logic          tick;
    logic          timeout;
    logic [11:0]   angle_inc;
    logic [12:0]   acnt_inc;

    always_comb begin
        tick      = (tick_q == TICK_LAST);
        tick_d    = tick ? '0 : tick_q + 1'b1;
        // An ACP arriving in the same cycle the timer expires counts as rotation.
        timeout   = (timer_q == TO_VAL) && !acp_e;
        angle_inc = (angle_q == ANG_LAST) ? 12'd0 : angle_q + 12'd1;
        acnt_inc  = (acnt_q == CNT_MAX) ? acnt_q : acnt_q + 13'd1;

        state_d     = state_q;
        angle_d     = angle_q;
        acnt_d      = acnt_q;
        rev_cnt_d   = rev_cnt_q;
        rev_err_d   = rev_err_q;
        arp_pulse_d = arp_e;

        if (acp_e) begin
            timer_d = '0;
        end else if (tick && timer_q != TO_VAL) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        case (state_q)
            S_SEARCH: begin
                if (timeout) begin
                    state_d = S_LOST;
                end else if (arp_e) begin
                    state_d = S_TRACK;
                    angle_d = 12'd0;
                    acnt_d  = 13'd0;
                end
            end
            S_TRACK: begin
                if (timeout) begin
                    state_d = S_LOST;
                end else if (arp_e) begin
                    // A coincident ACP closes the old revolution, not the new one.
                    rev_cnt_d = acp_e ? acnt_inc : acnt_q;
                    rev_err_d = (rev_cnt_d != REV_EXP);
                    angle_d   = 12'd0;
                    acnt_d    = 13'd0;
                end else if (acp_e) begin
                    angle_d = angle_inc;
                    acnt_d  = acnt_inc;
                end
            end
            S_LOST: begin
                if (acp_e) begin
                    state_d = S_SEARCH;
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_SEARCH;
            tick_q      <= '0;
            timer_q     <= '0;
            angle_q     <= 12'd0;
            acnt_q      <= 13'd0;
            rev_cnt_q   <= 13'd0;
            rev_err_q   <= 1'b0;
            arp_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            timer_q     <= timer_d;
            angle_q     <= angle_d;
            acnt_q      <= acnt_d;
            rev_cnt_q   <= rev_cnt_d;
            rev_err_q   <= rev_err_d;
            arp_pulse_q <= arp_pulse_d;
        end
    end

    assign angle     = angle_q;
    assign angle_vld = (state_q == S_TRACK);
    assign lost      = (state_q == S_LOST);
    assign arp_pulse = arp_pulse_q;
    assign t5us      = tick;
    assign rev_cnt   = rev_cnt_q;
    assign rev_err   = rev_err_q;
endmodule

// File: tb/tb_acp_arp_counter.sv
// Bench for acp_arp_counter: window-based reference model compared every cycle,
// plus directed scenarios with literal expectations.

module tb_acp_arp_counter;
    localparam int FL  = 8;
    localparam int APR = 16;
    localparam int TD  = 200;
    localparam int TO  = 10;

    localparam int M_SEARCH = 0, M_TRACK = 1, M_LOST = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        acp_in = 1'b0;
    logic        arp_in = 1'b0;
    logic [11:0] angle;
    logic        angle_vld, arp_pulse, t5us, rev_err, lost;
    logic [12:0] rev_cnt;

    always #5 clk = ~clk;

    acp_arp_counter #(.FILT_LEN(FL), .ACP_PER_REV(APR), .TICK_DIV(TD), .ACP_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .acp_in(acp_in), .arp_in(arp_in),
        .angle(angle), .angle_vld(angle_vld), .arp_pulse(arp_pulse), .t5us(t5us),
        .rev_cnt(rev_cnt), .rev_err(rev_err), .lost(lost)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit run_chk = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: an input is accepted when F consecutive raw samples agree,
    // and the effect lands 4 edges after the window completes.
    int m_state, m_angle, m_acnt, m_rev, m_err, m_pulse, m_timer, m_t5, ph, n_edge;
    int run_val[2], run_len[2], mf[2], raw_s[2];
    int due_acp[$], due_arp[$];

    initial begin
        bit acp_ev, arp_ev, tick;
        int tot;
        n_edge = 0;
        forever begin
            @(posedge clk);
            n_edge++;
            if (!reset) begin
                for (int i = 0; i < 2; i++) begin run_val[i] = 0; run_len[i] = FL; mf[i] = 0; end
                due_acp.delete(); due_arp.delete();
                m_state = M_SEARCH; m_angle = 0; m_acnt = 0; m_rev = 0; m_err = 0;
                m_pulse = 0; m_timer = 0; ph = 0; m_t5 = 0;
            end else begin
                tick = (m_t5 != 0);
                raw_s[0] = int'(acp_in); raw_s[1] = int'(arp_in);
                for (int i = 0; i < 2; i++) begin
                    if (raw_s[i] == run_val[i]) begin
                        if (run_len[i] < FL) run_len[i]++;
                    end else begin
                        run_val[i] = raw_s[i]; run_len[i] = 1;
                    end
                    if (run_len[i] >= FL && run_val[i] != mf[i]) begin
                        mf[i] = run_val[i];
                        if (mf[i] != 0) begin
                            if (i == 0) due_acp.push_back(n_edge + 4);
                            else due_arp.push_back(n_edge + 4);
                        end
                    end
                end
                acp_ev = (due_acp.size() > 0) && (due_acp[0] == n_edge);
                if (acp_ev) void'(due_acp.pop_front());
                arp_ev = (due_arp.size() > 0) && (due_arp[0] == n_edge);
                if (arp_ev) void'(due_arp.pop_front());
                m_pulse = int'(arp_ev);
                if (m_state == M_LOST) begin
                    if (acp_ev) m_state = M_SEARCH;
                end else if (m_timer >= TO && !acp_ev) begin
                    m_state = M_LOST;
                end else if (m_state == M_SEARCH) begin
                    if (arp_ev) begin m_state = M_TRACK; m_angle = 0; m_acnt = 0; end
                end else begin
                    if (arp_ev) begin
                        tot = m_acnt + int'(acp_ev);
                        if (tot > 8191) tot = 8191;
                        m_rev = tot; m_err = int'(tot != APR); m_angle = 0; m_acnt = 0;
                    end else if (acp_ev) begin
                        m_angle = (m_angle + 1) % APR;
                        if (m_acnt < 8191) m_acnt++;
                    end
                end
                if (acp_ev) m_timer = 0;
                else if (tick && m_timer < TO) m_timer++;
                ph++;
                m_t5 = int'((ph % TD) == TD - 1);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (run_chk) begin
            check("angle", int'(angle), m_angle);
            check("angle_vld", int'(angle_vld), int'(m_state == M_TRACK));
            check("lost", int'(lost), int'(m_state == M_LOST));
            check("arp_pulse", int'(arp_pulse), m_pulse);
            check("t5us", int'(t5us), m_t5);
            check("rev_cnt", int'(rev_cnt), m_rev);
            check("rev_err", int'(rev_err), m_err);
        end
    end

    task automatic pulse(input bit a, input bit r, input int w, input int gap);
        acp_in = a; arp_in = r;
        repeat (w) @(negedge clk);
        acp_in = 1'b0; arp_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic acps(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 10, 10);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_angle"}, int'(angle), 0);
        check({tag, "_vld"}, int'(angle_vld), 0);
        check({tag, "_arp_pulse"}, int'(arp_pulse), 0);
        check({tag, "_t5us"}, int'(t5us), 0);
        check({tag, "_rev_cnt"}, int'(rev_cnt), 0);
        check({tag, "_rev_err"}, int'(rev_err), 0);
        check({tag, "_lost"}, int'(lost), 0);
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        run_chk = 1;
        check_reset_vals("rst");
        reset = 1'b1;

        // 1: north, full revolution, north again
        pulse(1'b0, 1'b1, 10, 10);
        check("t1_vld", int'(angle_vld), 1);
        acps(APR - 1);
        check("t1_angle15", int'(angle), APR - 1);
        acps(1);
        check("t1_wrap0", int'(angle), 0);
        pulse(1'b0, 1'b1, 10, 10);
        check("t1_rev", int'(rev_cnt), APR);
        check("t1_err", int'(rev_err), 0);
        check("t1_angle", int'(angle), 0);

        // 2: 7-clk glitch ignored, 9-clk pulse accepted after exactly 11 clk
        pulse(1'b1, 1'b0, 7, 13);
        check("t2_glitch", int'(angle), 0);
        acp_in = 1'b1;
        repeat (9) @(negedge clk);
        acp_in = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_lat_before", int'(angle), 0);
        @(negedge clk);
        check("t2_lat_at", int'(angle), 1);
        repeat (8) @(negedge clk);

        // 3: short revolution, then a full one
        acps(APR - 2);
        pulse(1'b0, 1'b1, 10, 10);
        check("t3_rev_short", int'(rev_cnt), APR - 1);
        check("t3_err_short", int'(rev_err), 1);
        check("t3_angle", int'(angle), 0);
        acps(APR);
        pulse(1'b0, 1'b1, 10, 10);
        check("t3_rev_full", int'(rev_cnt), APR);
        check("t3_err_full", int'(rev_err), 0);

        // 4: ACP and ARP in the same clk closes the revolution
        acps(APR - 1);
        cnt = 0;
        acp_in = 1'b1; arp_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin acp_in = 1'b0; arp_in = 1'b0; end
            @(negedge clk);
            if (arp_pulse) cnt++;
        end
        check("t4_rev", int'(rev_cnt), APR);
        check("t4_err", int'(rev_err), 0);
        check("t4_angle", int'(angle), 0);
        check("t4_pulse_width", cnt, 1);

        // missed north: angle wraps, rev_cnt keeps the true total
        acps(APR + 4);
        check("wrap_angle", int'(angle), 4);
        pulse(1'b0, 1'b1, 10, 10);
        check("wrap_rev", int'(rev_cnt), APR + 4);
        check("wrap_err", int'(rev_err), 1);

        // 5: loss of rotation and recovery
        acps(3);
        cnt = 0;
        while (!lost && cnt < 3000) begin @(negedge clk); cnt++; end
        check("t5_lost", int'(lost), 1);
        check("t5_vld", int'(angle_vld), 0);
        check("t5_frozen", int'(angle), 3);
        pulse(1'b0, 1'b1, 10, 10);
        check("t5_arp_ignored", int'(lost), 1);
        check("t5_arp_angle", int'(angle), 3);
        acps(1);
        check("t5_resume_lost", int'(lost), 0);
        check("t5_resume_vld", int'(angle_vld), 0);
        pulse(1'b0, 1'b1, 10, 10);
        check("t5_track_vld", int'(angle_vld), 1);
        check("t5_track_angle", int'(angle), 0);

        // 6: tick period/width, then reset mid-revolution
        cnt = 0;
        while (!t5us && cnt < 400) begin @(negedge clk); cnt++; end
        @(negedge clk);
        check("t6_tick_width", int'(t5us), 0);
        cnt = 1;
        while (!t5us && cnt < 400) begin @(negedge clk); cnt++; end
        check("t6_tick_period", cnt, TD);
        acps(5);
        check("t6_pre_angle", int'(angle), 5);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b1;
        pulse(1'b0, 1'b1, 10, 10);
        acps(2);
        check("t6_recover", int'(angle), 2);

        run_chk = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
